timer_controller: RTL
=====================

Name: timer_controller

Overview:
Control FSM for the egg timer's MM:SS countdown. It owns the preset time and instantiates four digit_counter down-counters (seconds ones, seconds tens, minutes ones, minutes tens). It sequences their load and enable signals from a 1 Hz tick and debounced button pulses, and raises the alarm at 00:00. It sits between the button/tick front end and the 7-segment display driver.

Parameters:
DEFAULT_MIN, 8'h03, reset preset minutes, two BCD digits (00-99)
DEFAULT_SEC, 8'h00, reset preset seconds, two BCD digits (00-59)
ALARM_TICKS, 30, number of ticks ALARM lasts before auto-return to IDLE (1-255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
tick  in  1  single-cycle 1 Hz strobe, synchronous to clk
btn_start_stop  in  1  single-cycle pulse; start, pause or resume
btn_clear  in  1  single-cycle pulse; abort to IDLE
btn_inc_min  in  1  single-cycle pulse; preset minutes +1
btn_inc_sec  in  1  single-cycle pulse; preset seconds +1
digits  out  16  {min_tens, min_ones, sec_tens, sec_ones} BCD, taken from counter outputs
running  out  1  high in RUN
paused  out  1  high in PAUSE
alarm  out  1  high in ALARM
state  out  2  IDLE=0, RUN=1, PAUSE=2, ALARM=3

Behaviour:
- Reset (async): state=IDLE; preset = DEFAULT_MIN:DEFAULT_SEC; counters=0 so digits=16'h0000; running/paused/alarm=0; alarm tick counter=0. On the first clk edge after reset release, digits = preset.
- Counters: seconds ones MAX=9, seconds tens MAX=5, minutes ones MAX=9, minutes tens MAX=9, all DIRECTION=0. Each counter gets load = (state==IDLE) and start_count = its preset digit.
- IDLE: load is held every cycle, so digits track the preset one cycle after any preset change.
  - btn_inc_sec: preset seconds increments in BCD; 59 wraps to 00 with no carry into minutes.
  - btn_inc_min: preset minutes increments in BCD; 99 wraps to 00.
  - Both increment pulses in the same cycle: both apply.
  - btn_start_stop: preset != 00:00 -> RUN next cycle; preset == 00:00 -> ignored.
- RUN: enables are gated by tick, with a borrow chain through zero digits:
  - en_s0 = tick
  - en_s1 = tick & s0==0
  - en_m0 = tick & s0==0 & s1==0
  - en_m1 = tick & s0==0 & s1==0 & m0==0
  - Digits therefore decrement once per tick, e.g. 10:00 -> 09:59.
- Final tick: tick while digits==00:01 makes the counters go to 00:00 and state -> ALARM on the same edge.
- Other RUN transitions:
  - btn_clear -> IDLE (preset reloads next cycle).
  - btn_start_stop -> PAUSE. A tick in that same cycle is still applied. If that tick is the final tick, the state goes to ALARM, not PAUSE.
- PAUSE: all enables 0 and digits frozen.
  - btn_start_stop -> RUN.
  - btn_clear -> IDLE.
  - Ticks and increment buttons are ignored.
- ALARM: alarm=1 and digits hold 00:00. Enables are 0.
  - The alarm counter clears on entry and increments per tick.
  - At ALARM_TICKS ticks, or on btn_start_stop or btn_clear, state -> IDLE.
- Priority within a cycle: btn_clear over btn_start_stop. Increment buttons act only in IDLE and are ignored in every other state.
- Preset is never modified outside IDLE, so clearing from any state restores the last preset.
- Outputs running/paused/alarm/state are registered, i.e. decoded from the state register with no combinational path from inputs.
- Reset asserted mid-countdown: immediate return to the reset values above; the preset returns to the defaults.

Test Plan:
- Reset release with defaults -> state=0, digits=16'h0300 one cycle later. 60 inc_sec pulses -> preset back to 00. 97 inc_min pulses -> minutes 00.
- Preset 01:00, start, 1 tick -> digits 16'h0059, running=1. 59 more ticks -> digits 0000, alarm=1, state=3 on the same edge as the final tick.
- Preset 10:00, start, 1 tick -> 09:59 (borrow through all four digits).
- RUN at 00:30, start_stop -> PAUSE. 5 ticks -> digits stay 0030. start_stop -> RUN, 1 tick -> 0029. clear -> IDLE, digits = preset after 1 cycle.
- Preset 00:00, start_stop -> state stays IDLE. In ALARM with ALARM_TICKS=3: 3 ticks -> IDLE, alarm=0.
- start_stop and final tick in the same cycle at 00:01 -> ALARM (not PAUSE). clear and start_stop together in RUN -> IDLE.

Source files
------------

// File: rtl/timer_controller.sv
// Egg-timer MM:SS countdown control: preset storage, four BCD digit down-counters,
// run/pause/alarm sequencing from a 1 Hz tick and debounced button pulses.

module digit_counter #(
  parameter logic [3:0] MAX       = 4'd9,
  parameter bit         DIRECTION = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       enable,
  input  logic [3:0] start_count,
  output logic [3:0] count
);

  logic [3:0] count_r;

  // Digit register: load dominates enable; counts wrap between 0 and MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= 4'd0;
    end else if (load) begin
      count_r <= start_count;
    end else if (enable) begin
      if (DIRECTION == 1'b0) begin
        count_r <= (count_r == 4'd0) ? MAX : count_r - 4'd1;
      end else begin
        count_r <= (count_r >= MAX) ? 4'd0 : count_r + 4'd1;
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

module timer_controller #(
  parameter logic [7:0] DEFAULT_MIN = 8'h03,
  parameter logic [7:0] DEFAULT_SEC = 8'h00,
  parameter int         ALARM_TICKS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn_start_stop,
  input  logic        btn_clear,
  input  logic        btn_inc_min,
  input  logic        btn_inc_sec,
  output logic [15:0] digits,
  output logic        running,
  output logic        paused,
  output logic        alarm,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

  state_t     state_r;
  state_t     next_state_s;
  logic [7:0] preset_min_r;
  logic [7:0] preset_sec_r;
  logic [7:0] alarm_cnt_r;
  logic [3:0] s0_s, s1_s, m0_s, m1_s;
  logic       load_s;
  logic       en_s0_s, en_s1_s, en_m0_s, en_m1_s;
  logic       final_tick_s;
  logic       preset_zero_s;

  // BCD increment of a two-digit value; tens wrap to 0 once they reach tens_max.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] tens_max);
    logic [7:0] r;
    if (v[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      if (v[7:4] >= tens_max) begin
        r[7:4] = 4'd0;
      end else begin
        r[7:4] = v[7:4] + 4'd1;
      end
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  digit_counter #(.MAX(4'd9), .DIRECTION(1'b0)) u_sec_ones (
    .clk(clk), .reset(reset), .load(load_s), .enable(en_s0_s),
    .start_count(preset_sec_r[3:0]), .count(s0_s)
  );
  digit_counter #(.MAX(4'd5), .DIRECTION(1'b0)) u_sec_tens (
    .clk(clk), .reset(reset), .load(load_s), .enable(en_s1_s),
    .start_count(preset_sec_r[7:4]), .count(s1_s)
  );
  digit_counter #(.MAX(4'd9), .DIRECTION(1'b0)) u_min_ones (
    .clk(clk), .reset(reset), .load(load_s), .enable(en_m0_s),
    .start_count(preset_min_r[3:0]), .count(m0_s)
  );
  digit_counter #(.MAX(4'd9), .DIRECTION(1'b0)) u_min_tens (
    .clk(clk), .reset(reset), .load(load_s), .enable(en_m1_s),
    .start_count(preset_min_r[7:4]), .count(m1_s)
  );

  assign digits = {m1_s, m0_s, s1_s, s0_s};
  assign state  = state_r;

  // Counter control: load while idle, tick-gated borrow chain while running.
  always_comb begin
    load_s        = (state_r == IDLE);
    preset_zero_s = (preset_min_r == 8'h00) && (preset_sec_r == 8'h00);
    if (state_r == RUN) begin
      en_s0_s      = tick;
      en_s1_s      = tick && (s0_s == 4'd0);
      en_m0_s      = tick && (s0_s == 4'd0) && (s1_s == 4'd0);
      en_m1_s      = tick && (s0_s == 4'd0) && (s1_s == 4'd0) && (m0_s == 4'd0);
      final_tick_s = tick && (digits == 16'h0001);
    end else begin
      en_s0_s      = 1'b0;
      en_s1_s      = 1'b0;
      en_m0_s      = 1'b0;
      en_m1_s      = 1'b0;
      final_tick_s = 1'b0;
    end
  end

  // Next-state selection; clear beats start/stop, and the final tick beats pause.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (btn_clear) begin
          next_state_s = IDLE;
        end else if (btn_start_stop && !preset_zero_s) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (btn_clear) begin
          next_state_s = IDLE;
        end else if (final_tick_s) begin
          next_state_s = ALARM;
        end else if (btn_start_stop) begin
          next_state_s = PAUSE;
        end else begin
          next_state_s = RUN;
        end
      end
      PAUSE: begin
        if (btn_clear) begin
          next_state_s = IDLE;
        end else if (btn_start_stop) begin
          next_state_s = RUN;
        end else begin
          next_state_s = PAUSE;
        end
      end
      ALARM: begin
        if (btn_clear || btn_start_stop) begin
          next_state_s = IDLE;
        end else if (tick && (alarm_cnt_r >= ALARM_LAST)) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = ALARM;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register with status flags decoded from the next state so they stay in step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      running <= 1'b0;
      paused  <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      running <= (next_state_s == RUN);
      paused  <= (next_state_s == PAUSE);
      alarm   <= (next_state_s == ALARM);
    end
  end

  // Alarm duration counter; held at zero outside ALARM so each entry starts fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_cnt_r <= 8'd0;
    end else if (state_r != ALARM) begin
      alarm_cnt_r <= 8'd0;
    end else if (tick) begin
      alarm_cnt_r <= alarm_cnt_r + 8'd1;
    end else begin
      alarm_cnt_r <= alarm_cnt_r;
    end
  end

  // Preset registers; only the idle state may edit them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      preset_min_r <= DEFAULT_MIN;
      preset_sec_r <= DEFAULT_SEC;
    end else if (state_r == IDLE) begin
      if (btn_inc_min) begin
        preset_min_r <= bcd_inc(preset_min_r, 4'd9);
      end else begin
        preset_min_r <= preset_min_r;
      end
      if (btn_inc_sec) begin
        preset_sec_r <= bcd_inc(preset_sec_r, 4'd5);
      end else begin
        preset_sec_r <= preset_sec_r;
      end
    end else begin
      preset_min_r <= preset_min_r;
      preset_sec_r <= preset_sec_r;
    end
  end

endmodule

module timer_controller_chk (
  input logic        clk,
  input logic        reset,
  input logic [15:0] digits,
  input logic        running,
  input logic        paused,
  input logic        alarm,
  input logic [1:0]  state
);

  a_running: assert property (@(posedge clk) disable iff (reset) running == (state == 2'd1));
  a_paused:  assert property (@(posedge clk) disable iff (reset) paused == (state == 2'd2));
  a_alarm:   assert property (@(posedge clk) disable iff (reset) alarm == (state == 2'd3));
  a_alarm_z: assert property (@(posedge clk) disable iff (reset) alarm |-> (digits == 16'h0000));
  a_bcd:     assert property (@(posedge clk) disable iff (reset)
                              (digits[3:0] <= 4'd9) && (digits[7:4] <= 4'd5) &&
                              (digits[11:8] <= 4'd9) && (digits[15:12] <= 4'd9));

endmodule
